// File: rtl/mdu_hilo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdu_hilo: multiply/divide unit owning the HI/LO architectural registers.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mdu_hilo #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_cnt_w = $clog2(WIDTH + MUL_STAGES + 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_mul  = 2'd1;
  localparam logic [1:0] c_st_div  = 2'd2;

  localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(MUL_STAGES - 1);
  localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_src1;
  logic [WIDTH-1:0]   r_src2;
  logic               r_signed;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_accept;
  logic               w_acc_signed;
  logic [WIDTH-1:0]   w_src1_mag;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_div_mag;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_div_zero;
  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;

  assign busy = (r_state != c_st_idle);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  assign w_accept     = start & ~flush & (r_state == c_st_idle);
  assign w_acc_signed = ~op[0];
  assign w_src1_mag   = (w_acc_signed & src1[WIDTH-1]) ? -src1 : src1;

  assign w_a_neg   = r_signed & r_src1[WIDTH-1];
  assign w_b_neg   = r_signed & r_src2[WIDTH-1];
  assign w_div_mag = w_b_neg ? -r_src2 : r_src2;

  // Extending to 2*WIDTH makes one unsigned multiply serve both MULT and MULTU.
  assign w_mul_a = {{WIDTH{w_a_neg}}, r_src1};
  assign w_mul_b = {{WIDTH{w_b_neg}}, r_src2};
  assign w_prod  = w_mul_a * w_mul_b;

  // Restoring step: the partial remainder stays below the divisor, so the
  // difference always fits in WIDTH bits when the subtraction is taken.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, w_div_mag});
  assign w_sub   = w_shift[WIDTH-1:0] - w_div_mag;

  assign w_quo_fix  = (w_a_neg ^ w_b_neg) ? -r_quo : r_quo;
  assign w_rem_fix  = w_a_neg ? -r_rem : r_rem;
  assign w_div_zero = (r_src2 == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= c_st_idle;
      r_cnt    <= '0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_signed <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            case (op)
              3'b000, 3'b001: begin
                r_state  <= c_st_mul;
                r_cnt    <= c_mul_last;
                r_src1   <= src1;
                r_src2   <= src2;
                r_signed <= w_acc_signed;
              end
              3'b010, 3'b011: begin
                r_state  <= c_st_div;
                r_cnt    <= c_div_last;
                r_src1   <= src1;
                r_src2   <= src2;
                r_signed <= w_acc_signed;
                r_quo    <= w_src1_mag;
                r_rem    <= '0;
              end
              3'b100:  r_hi <= src1;
              3'b101:  r_lo <= src1;
              default: ;
            endcase
          end
        end
        c_st_mul: begin
          if (flush) begin
            r_state <= c_st_idle;
          end else if (r_cnt == '0) begin
            r_hi    <= w_prod[2*WIDTH-1:WIDTH];
            r_lo    <= w_prod[WIDTH-1:0];
            r_done  <= 1'b1;
            r_state <= c_st_idle;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        c_st_div: begin
          if (flush) begin
            r_state <= c_st_idle;
          end else if (r_cnt == '0) begin
            // Final cycle: sign fix-up, or the divide-by-zero result.
            if (w_div_zero) begin
              r_hi <= r_src1;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
            r_done  <= 1'b1;
            r_state <= c_st_idle;
          end else begin
            r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mdu_hilo: randomized and directed self-checking bench for mdu_hilo.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_mdu_hilo;

  localparam int W    = 32;
  localparam int MS   = 2;
  localparam int LDIV = W + 1;

  logic         clk   = 1'b0;
  logic         rstn  = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op    = 3'b110;
  logic [W-1:0] src1  = '0;
  logic [W-1:0] src2  = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] m_hi    = '0;
  logic [W-1:0] m_lo    = '0;

  always #5 clk = ~clk;

  mdu_hilo #(.WIDTH(W), .MUL_STAGES(MS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .start(start),
    .op   (op),
    .src1 (src1),
    .src2 (src2),
    .flush(flush),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0]     res;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (o)
      3'b000: begin sp = sa * sb; res = sp; end
      3'b001: begin up = ua * ub; res = up; end
      3'b010, 3'b011: begin
        if (b == '0) res = {a, 32'hFFFF_FFFF};
        else if (o == 3'b010) begin
          sq = sa / sb; sr = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end else begin
          up = ua / ub; sp = longint'(ua % ub);
          res = {sp[31:0], up[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Drives one request so it is sampled at the next rising edge (E0), then
  // scrambles the inputs to expose any failure to latch them.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); src1 = $urandom; src2 = $urandom;
  endtask

  // Returns the number of edges after E0 until done is seen (bounded), and
  // whether busy was high (and done low) on every cycle before that.
  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b1;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
      if (!busy) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (hi !== '0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_tests++; if (lo !== '0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_mul_directed();
    logic [2:0]   ops [3] = '{3'b000, 3'b001, 3'b000};
    logic [W-1:0] as  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] bs  [3] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [63:0]  exp [3] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001};
    int cyc; bit ok;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul%0d_busy_e0 got %b want 1", i, busy); end
      wait_done(cyc, ok);
      n_tests++; if (cyc != MS) begin n_fail++; $display("FAIL mul%0d_latency got %0d want %0d", i, cyc, MS); end
      n_tests++; if (!ok || busy !== 1'b0) begin n_fail++; $display("FAIL mul%0d_busy got ok=%b busy=%b want ok=1 busy=0", i, ok, busy); end
      n_tests++; if ({hi, lo} !== exp[i]) begin n_fail++; $display("FAIL mul%0d_result got %h_%h want %h", i, hi, lo, exp[i]); end
      m_hi = exp[i][63:32]; m_lo = exp[i][31:0];
      @(posedge clk); #1;
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul%0d_done_pulse got %b want 0", i, done); end
    end
  endtask

  task automatic test_div_directed();
    logic [2:0]   ops [4] = '{3'b010, 3'b011, 3'b010, 3'b011};
    logic [W-1:0] as  [4] = '{32'hFFFF_FFF9, 32'h0000_0064, 32'h8000_0000, 32'h0000_1234};
    logic [W-1:0] bs  [4] = '{32'h0000_0002, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [63:0]  exp [4] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                              64'h0000_0000_8000_0000, 64'h0000_1234_FFFF_FFFF};
    int cyc; bit ok;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(cyc, ok);
      n_tests++; if (cyc != LDIV) begin n_fail++; $display("FAIL div%0d_latency got %0d want %0d", i, cyc, LDIV); end
      n_tests++; if (!ok || busy !== 1'b0) begin n_fail++; $display("FAIL div%0d_busy got ok=%b busy=%b want ok=1 busy=0", i, ok, busy); end
      n_tests++; if ({hi, lo} !== exp[i]) begin n_fail++; $display("FAIL div%0d_result got %h_%h want %h", i, hi, lo, exp[i]); end
      m_hi = exp[i][63:32]; m_lo = exp[i][31:0];
      @(posedge clk); #1;
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL div%0d_done_pulse got %b want 0", i, done); end
    end
  endtask

  task automatic test_ignore_and_flush();
    bit saw_done;
    issue(3'b010, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b100; src1 = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++; if (hi !== m_hi) begin n_fail++; $display("FAIL busy_mthi_hi got %h want %h", hi, m_hi); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_mthi_busy got %b want 1", busy); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    n_tests++; if (saw_done) begin n_fail++; $display("FAIL flush_done got 1 want 0"); end
    n_tests++; if ({hi, lo} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL flush_hilo got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
    issue(3'b101, 32'h1234_5678, 32'h0);
    m_lo = 32'h1234_5678;
    n_tests++; if (lo !== m_lo || hi !== m_hi) begin n_fail++; $display("FAIL mtlo_hilo got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_flush_on_commit();
    int cyc;
    issue(3'b001, 32'h0000_0003, 32'h0000_0004);
    repeat (MS - 1) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cyc = 0;
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_commit got busy=%b done=%b want 0 0", busy, done); end
    n_tests++; if ({hi, lo} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL flush_commit_hilo got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_random();
    logic [2:0]   o;
    logic [W-1:0] a, b;
    logic [63:0]  exp;
    int cyc, lat; bit ok;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = rnd_operand();
      b = rnd_operand();
      issue(o, a, b);
      if (o[2]) begin
        if (o == 3'b100) m_hi = a;
        if (o == 3'b101) m_lo = a;
        n_tests++; if ({hi, lo, busy, done} !== {m_hi, m_lo, 2'b00}) begin n_fail++;
          $display("FAIL rnd%0d_op%0d got %h_%h b%b d%b want %h_%h b0 d0", i, o, hi, lo, busy, done, m_hi, m_lo); end
      end else begin
        exp = model(o, a, b);
        lat = o[1] ? LDIV : MS;
        wait_done(cyc, ok);
        n_tests++; if (cyc != lat || !ok) begin n_fail++; $display("FAIL rnd%0d_timing got %0d ok=%b want %0d", i, cyc, ok, lat); end
        n_tests++; if ({hi, lo} !== exp) begin n_fail++;
          $display("FAIL rnd%0d_op%0d a=%h b=%h got %h_%h want %h", i, o, a, b, hi, lo, exp); end
        m_hi = exp[63:32]; m_lo = exp[31:0];
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   o [6];
    logic [W-1:0] a [6], b [6];
    logic [63:0]  exp;
    int cyc; bit ok;
    for (int i = 0; i < 6; i++) begin
      o[i] = 3'(i % 4); a[i] = rnd_operand(); b[i] = rnd_operand();
    end
    issue(o[0], a[0], b[0]);
    for (int i = 0; i < 6; i++) begin
      exp = model(o[i], a[i], b[i]);
      wait_done(cyc, ok);
      n_tests++; if (cyc != (o[i][1] ? LDIV : MS) || !ok) begin n_fail++; $display("FAIL b2b%0d_timing got %0d ok=%b", i, cyc, ok); end
      n_tests++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL b2b%0d_result got %h_%h want %h", i, hi, lo, exp); end
      m_hi = exp[63:32]; m_lo = exp[31:0];
      if (i < 5) begin
        issue(o[i+1], a[i+1], b[i+1]);
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_accept got busy=%b done=%b want 1 0", i, busy, done); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int cyc; bit ok;
    issue(3'b001, 32'hDEAD_BEEF, 32'h1234_5678);
    #2;
    rstn = 1'b0;
    #1;
    n_tests++; if ({hi, lo} !== '0) begin n_fail++; $display("FAIL arst_hilo got %h_%h want 0_0", hi, lo); end
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL arst_flags got busy=%b done=%b want 0 0", busy, done); end
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    issue(3'b011, 32'd9, 32'd3);
    wait_done(cyc, ok);
    n_tests++; if (cyc != LDIV || !ok) begin n_fail++; $display("FAIL arst_divu_timing got %0d ok=%b want %0d", cyc, ok, LDIV); end
    n_tests++; if (lo !== 32'd3 || hi !== 32'd0) begin n_fail++; $display("FAIL arst_divu got %h_%h want 00000000_00000003", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_ignore_and_flush();
    test_flush_on_commit();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
